// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), one bit per clock, LSB first.
// Optional signed-overflow output `ovf` is enabled by defining SERSUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic ai;
  logic bi;
  logic d;
  logic br_nxt;
  logic last;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    ai     = a_sh[0];
    bi     = b_sh[0];
    d      = ai ^ bi ^ br;
    br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // On the final bit the visible outputs take the completed result; until then they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d, res_sh[WIDTH-1:1]};
          br     <= br_nxt;
          cnt    <= cnt + 1'b1;
          if (last) begin
            diff <= {d, res_sh[WIDTH-1:1]};
            bout <= br_nxt;
`ifdef SERSUB_OVF_EN
            // ai/bi are the operand MSBs here; d is the result MSB.
            ovf  <= (ai != bi) && (d != ai);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
